// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and baud divisor helper for the UART receiver.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  function automatic int uart_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// 16x oversampling tick generator: one-clk tick every DIV clocks, restartable via clr.
module uart_rx_tick_gen #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  import uart_pkg::*;

  localparam int DIV = uart_div(CLK_FREQ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver: input synchronizer, mid-bit sampling FSM, framed byte output.
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       frame_err,
  output logic       busy
);
  import uart_pkg::*;

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [3:0] MID_LAST = 4'(MID_TICK - 1);
  localparam logic [3:0] BIT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] IDX_LAST = BIT_W'(DATA_BITS - 1);

  logic                 r_sync1, r_sync2;
  rx_state_t            r_state;
  logic [3:0]           r_tick_cnt;
  logic [BIT_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_ferr;
  logic                 w_rx, w_tick, w_clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx  = r_sync2;
  // Restart the divider on the start edge so tick phase is aligned to the frame
  assign w_clr = (r_state == IDLE) && !w_rx;

  uart_rx_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rx) begin
            r_tick_cnt <= '0;
            r_state    <= START;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_tick_cnt == MID_LAST) begin
              if (w_rx) begin
                r_state <= IDLE;
              end else begin
                r_tick_cnt <= '0;
                r_bit_idx  <= '0;
                r_state    <= DATA;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_tick_cnt == BIT_LAST) begin
              r_tick_cnt         <= '0;
              r_shift[r_bit_idx] <= w_rx;
              r_bit_idx          <= r_bit_idx + 1'b1;
              if (r_bit_idx == IDX_LAST) r_state <= STOP;
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_tick_cnt == BIT_LAST) begin
              r_tick_cnt <= '0;
              r_data     <= r_shift;
              if (w_rx) begin
                r_valid <= 1'b1;
                r_state <= IDLE;
              end else begin
                r_ferr  <= 1'b1;
                r_state <= WAIT_IDLE;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        WAIT_IDLE: begin
          // A held-low line must not be mistaken for the next start bit
          if (w_rx) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx at DIV=10 (160 clk per bit).
module tb_uart_rx;

  localparam int BIT_CLK = 160;

  typedef struct {
    logic       err;
    logic [7:0] d;
    int         cyc;
  } ev_t;

  typedef struct {
    logic       err;
    logic [7:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic [7:0] data_out;
  logic       valid_out, frame_err, busy;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  ev_t  evq[$];
  exp_t expq[$];

  uart_rx #(
    .CLK_FREQ   (1_600_000),
    .BAUD       (10_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .serial_in (serial_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_out) evq.push_back('{1'b0, data_out, cyc});
    if (frame_err) evq.push_back('{1'b1, data_out, cyc});
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int got, input int lo, input int hi);
    tests++;
    assert (got >= lo && got <= hi) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, got, lo, hi);
    end
  endtask

  function automatic ev_t get_ev(input int i);
    ev_t e;
    if (i < evq.size()) return evq[i];
    e.err = 1'bx;
    e.d   = 8'hxx;
    e.cyc = -100000;
    return e;
  endfunction

  // caller is at posedge+1; holds the level for one bit time and returns at posedge+1
  task automatic drive_bit(input logic v);
    serial_in = v;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int   t0, t1;
    ev_t  e0, e1;
    logic [7:0] rb;
    logic       rs;
    int         gap;

    reset     = 1'b0;
    serial_in = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_data", data_out, 8'h00);
    check("rst_valid", valid_out, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);

    // idle line
    @(posedge clk); #1;
    evq.delete(); busy_cnt = 0;
    idle(5000);
    check("idle_events", evq.size(), 0);
    check("idle_busy_cycles", busy_cnt, 0);
    check("idle_data", data_out, 8'h00);

    // single frame A5
    evq.delete();
    send_frame(8'hA5, 1'b1, t0);
    idle(20);
    check("a5_count", evq.size(), 1);
    e0 = get_ev(0);
    check("a5_err", e0.err, 1'b0);
    check("a5_data", e0.d, 8'hA5);
    check_rng("a5_latency", e0.cyc - t0, 1515, 1540);
    check("a5_hold", data_out, 8'hA5);

    // back-to-back 00 then FF, no idle gap
    evq.delete();
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t1);
    idle(20);
    check("b2b_count", evq.size(), 2);
    e0 = get_ev(0);
    e1 = get_ev(1);
    check("b2b_d0", e0.d, 8'h00);
    check("b2b_d1", e1.d, 8'hFF);
    check("b2b_err", {e0.err, e1.err}, 2'b00);
    check_rng("b2b_spacing", e1.cyc - e0.cyc, 1598, 1602);

    // false start: 40-clk glitch
    idle(100);
    evq.delete(); busy_cnt = 0;
    serial_in = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    serial_in = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    check("fs_events", evq.size(), 0);
    check_rng("fs_busy_cycles", busy_cnt, 75, 90);
    check("fs_busy_end", busy, 1'b0);

    // framing error on 3C, line held low, then a good 81
    evq.delete();
    send_frame(8'h3C, 1'b0, t0);
    serial_in = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    check("fe_count", evq.size(), 1);
    e0 = get_ev(0);
    check("fe_err", e0.err, 1'b1);
    check("fe_data", e0.d, 8'h3C);
    check("fe_busy_low_line", busy, 1'b1);
    check("fe_data_hold", data_out, 8'h3C);
    idle(10);
    check("fe_busy_after", busy, 1'b0);
    evq.delete();
    send_frame(8'h81, 1'b1, t0);
    idle(20);
    check("post_fe_count", evq.size(), 1);
    e0 = get_ev(0);
    check("post_fe_frame", {e0.err, e0.d}, {1'b0, 8'h81});

    // reset in the middle of bit 4 of 5A
    evq.delete();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(rb_bit(8'h5A, i));
    serial_in = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_data", data_out, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    serial_in = 1'b1;
    reset = 1'b1;
    idle(200);
    check("mid_rst_events", evq.size(), 0);
    send_frame(8'h12, 1'b1, t0);
    idle(20);
    check("after_rst_count", evq.size(), 1);
    e0 = get_ev(0);
    check("after_rst_frame", {e0.err, e0.d}, {1'b0, 8'h12});

    // randomized stream against a frame-level reference
    evq.delete();
    expq.delete();
    for (int n = 0; n < 10; n++) begin
      rb  = 8'($urandom_range(0, 255));
      rs  = ($urandom_range(0, 3) != 0);
      gap = rs ? $urandom_range(0, 40) : $urandom_range(30, 80);
      expq.push_back('{~rs, rb});
      send_frame(rb, rs, t0);
      idle(gap);
    end
    idle(200);
    check("rnd_count", evq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      e0 = get_ev(i);
      check($sformatf("rnd_err_%0d", i), e0.err, expq[i].err);
      check($sformatf("rnd_data_%0d", i), e0.d, expq[i].d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic logic rb_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction

endmodule
